data_memory_ctrl: RTL and testbench

- Parametrised successor to the single-cycle word-only data memory, sitting on the MEM stage of the RISC-V pipeline.
- Supports all RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes and sign/zero extension.
- Uses a configurable-latency request/response handshake so the pipeline can model slow memory and stall on req_ready.
- Detects misaligned and illegal accesses and reports them on resp_fault.

---
 rtl/data_memory_ctrl_if.sv | 23 ++
 rtl/data_memory_ctrl.sv | 142 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage and data_memory_ctrl.
// The master drives requests and the controller (slave) returns one response per request.
interface data_memory_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_fault;

    modport master (
        output req_valid, req_write, funct3, addr, write_data,
        input  req_ready, resp_valid, resp_data, resp_fault
    );

    modport slave (
        input  req_valid, req_write, funct3, addr, write_data,
        output req_ready, resp_valid, resp_data, resp_fault
    );
endinterface

// File: rtl/data_memory_ctrl.sv
// RV32I data memory with byte-lane stores, sign/zero-extended loads and configurable latency.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of masking the low bits.
module data_memory_ctrl #(
    parameter int          DEPTH_WORDS = 2048,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] INIT_WORD0  = 32'h00000007
) (
    input logic               clk,
    input logic               rst,
    data_memory_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             r_state;
    logic               r_ready;
    logic               r_respValid;
    logic               r_respFault;
    logic [31:0]        r_respData;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_write;
    logic [2:0]         r_funct3;
    logic [IDX_W+1:0]   r_addr;
    logic [31:0]        r_wdata;

    // Contents exist from time 0 and survive rst.
    logic [31:0] r_mem [DEPTH_WORDS] = '{0: INIT_WORD0, default: 32'h0};

    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_word;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic             w_illegal;
    logic             w_misalign;
    logic             w_fault;
    logic             w_exec;
    logic             w_doWrite;
    logic [31:0]      w_loadData;
    logic [31:0]      w_storeData;
    logic [3:0]       w_byteEn;

    assign w_idx   = r_addr[IDX_W+1:2];
    assign w_word  = r_mem[w_idx];
    assign w_byte  = w_word[{r_addr[1:0], 3'b000} +: 8];
    assign w_half  = r_addr[1] ? w_word[31:16] : w_word[15:0];
    assign w_fault = w_illegal | w_misalign;
    assign w_exec  = (r_state == BUSY) && (r_cnt == '0);
    assign w_doWrite = w_exec && r_write && !w_fault && !rst;

    always_comb begin
        if (r_write) w_illegal = (r_funct3 > 3'd2);
        else         w_illegal = (r_funct3 == 3'b011) || (r_funct3[2:1] == 2'b11);
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                        ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // funct3[1:0] selects size, funct3[2] selects zero extension; illegal codes are masked by w_fault.
    always_comb begin
        w_loadData  = '0;
        w_byteEn    = '0;
        w_storeData = r_wdata;
        case (r_funct3[1:0])
            2'b00: begin
                w_loadData  = r_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                w_byteEn    = 4'b0001 << r_addr[1:0];
                w_storeData = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_loadData  = r_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                w_byteEn    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_storeData = {2{r_wdata[15:0]}};
            end
            2'b10: begin
                w_loadData = w_word;
                w_byteEn   = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) r_mem[w_idx][8*b +: 8] <= w_storeData[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ready     <= 1'b1;
            r_respValid <= 1'b0;
            r_respData  <= '0;
            r_respFault <= 1'b0;
            r_cnt       <= '0;
            r_write     <= 1'b0;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            r_respValid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write  <= bus.req_write;
                        r_funct3 <= bus.funct3;
                        r_addr   <= bus.addr[IDX_W+1:0];
                        r_wdata  <= bus.write_data;
                        r_cnt    <= CNT_W'(LATENCY - 1);
                        r_ready  <= 1'b0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_respValid <= 1'b1;
                        r_respFault <= w_fault;
                        r_respData  <= (r_write || w_fault) ? 32'h0 : w_loadData;
                        r_ready     <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_respValid;
    assign bus.resp_data  = r_respData;
    assign bus.resp_fault = r_respFault;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: one LATENCY=1 and one LATENCY=3 instance checked against a byte-array model.
// Honours DMEM_MISALIGN_TRAP_EN the same way the design does.
module tb_data_memory_ctrl;
    localparam int DEPTH = 2048;
    localparam int BYTES = DEPTH * 4;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;

    always #5 clk = ~clk;

    data_memory_ctrl_if bus1();
    data_memory_ctrl_if bus3();

    data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .INIT_WORD0(32'h00000007)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .INIT_WORD0(32'h00000007)) u_dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (bus3)
    );

    int testCount = 0;
    int failCount = 0;
    logic [7:0] refMem [2][BYTES];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic driveReq(input int sel, input logic v, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
        if (sel == 1) begin
            bus1.req_valid = v; bus1.req_write = wr; bus1.funct3 = f3;
            bus1.addr = a; bus1.write_data = wd;
        end else begin
            bus3.req_valid = v; bus3.req_write = wr; bus3.funct3 = f3;
            bus3.addr = a; bus3.write_data = wd;
        end
    endtask

    task automatic sampleBus(input int sel, output logic rdy, output logic rv,
                             output logic [31:0] rd, output logic rf);
        if (sel == 1) begin
            rdy = bus1.req_ready; rv = bus1.resp_valid; rd = bus1.resp_data; rf = bus1.resp_fault;
        end else begin
            rdy = bus3.req_ready; rv = bus3.resp_valid; rd = bus3.resp_data; rf = bus3.resp_fault;
        end
    endtask

    // Little-endian byte-addressed memory; results follow the RV32I load/store rules directly.
    function automatic void modelAccess(input int sel, input logic wr, input logic [2:0] f3,
                                        input logic [31:0] a, input logic [31:0] wd,
                                        output logic [31:0] expData, output logic expFault);
        int m;
        int size;
        int base;
        logic legal;
        logic [31:0] eff;
        logic [31:0] raw;
        m = (sel == 1) ? 0 : 1;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        expData = 32'h0;
        expFault = !legal;
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((a % size) != 0) expFault = 1'b1;
`endif
        if (expFault) return;
        eff = a & ~32'(size - 1);
        base = int'(eff % BYTES);
        if (wr) begin
            for (int i = 0; i < size; i++) refMem[m][base + i] = wd[8*i +: 8];
        end else begin
            raw = 32'h0;
            for (int i = 0; i < size; i++) raw = raw | (32'(refMem[m][base + i]) << (8 * i));
            if (!f3[2] && size < 4 && raw[8*size-1]) raw = raw | ~((32'd1 << (8 * size)) - 32'd1);
            expData = raw;
        end
    endfunction

    // Called at a negedge with the DUT idle (or in its response cycle); returns at the response cycle.
    task automatic applyStimulus(input int sel, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd, input logic hold,
                                 input string tag, output logic [31:0] obsData);
        int lat;
        int low;
        logic got;
        logic expF, rdy, rv, rf;
        logic [31:0] expD, rd;
        lat = (sel == 1) ? 1 : 3;
        low = 0;
        got = 1'b0;
        modelAccess(sel, wr, f3, a, wd, expD, expF);
        sampleBus(sel, rdy, rv, rd, rf);
        checkOutput({tag, "_readyIdle"}, {31'h0, rdy}, 32'h1);
        driveReq(sel, 1'b1, wr, f3, a, wd);
        @(negedge clk);
        // While BUSY the inputs must be ignored, so scramble them when the request is held.
        if (hold) driveReq(sel, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
        else      driveReq(sel, 1'b0, 1'b0, 3'h0, 32'h0, 32'h0);
        sampleBus(sel, rdy, rv, rd, rf);
        checkOutput({tag, "_accepted"}, {31'h0, rdy}, 32'h0);
        for (int c = 0; c < 40; c++) begin
            sampleBus(sel, rdy, rv, rd, rf);
            if (rv) begin
                got = 1'b1;
                break;
            end
            if (!rdy) low++;
            @(negedge clk);
        end
        checkOutput({tag, "_respSeen"}, {31'h0, got}, 32'h1);
        checkOutput({tag, "_readyLow"}, 32'(low), 32'(lat));
        checkOutput({tag, "_readyResp"}, {31'h0, rdy}, 32'h1);
        checkOutput({tag, "_data"}, rd, expD);
        checkOutput({tag, "_fault"}, {31'h0, rf}, {31'h0, expF});
        obsData = rd;
    endtask

    initial begin
        logic [31:0] d;
        logic rdy, rv, rf;
        logic [31:0] rd;
        int rvSeen;
        logic [31:0] a;

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < BYTES; i++) refMem[m][i] = 8'h00;
            refMem[m][0] = 8'h07;
        end
        rst1 = 1'b1;
        rst3 = 1'b1;
        driveReq(1, 1'b0, 1'b0, 3'h0, 32'h0, 32'h0);
        driveReq(3, 1'b0, 1'b0, 3'h0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);

        for (int s = 1; s <= 3; s += 2) begin
            sampleBus(s, rdy, rv, rd, rf);
            checkOutput($sformatf("rst%0d_ready", s), {31'h0, rdy}, 32'h1);
            checkOutput($sformatf("rst%0d_respValid", s), {31'h0, rv}, 32'h0);
            checkOutput($sformatf("rst%0d_respData", s), rd, 32'h0);
            checkOutput($sformatf("rst%0d_respFault", s), {31'h0, rf}, 32'h0);
        end
        rst1 = 1'b0;
        rst3 = 1'b0;

        applyStimulus(1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, "lwInit", d);
        checkOutput("lwInit_lit", d, 32'h00000007);
        applyStimulus(1, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, "sw10", d);
        applyStimulus(1, 1'b1, 3'b000, 32'h11, 32'h00000055, 1'b0, "sb11", d);
        applyStimulus(1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, "lw10", d);
        checkOutput("lw10_lit", d, 32'hDEAD55EF);
        applyStimulus(1, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0, "lb13", d);
        checkOutput("lb13_lit", d, 32'hFFFFFFDE);
        applyStimulus(1, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0, "lbu13", d);
        checkOutput("lbu13_lit", d, 32'h000000DE);
        applyStimulus(1, 1'b0, 3'b001, 32'h12, 32'h0, 1'b0, "lh12", d);
        checkOutput("lh12_lit", d, 32'hFFFFDEAD);
        applyStimulus(1, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, "lhu12", d);
        checkOutput("lhu12_lit", d, 32'h0000DEAD);

        applyStimulus(1, 1'b1, 3'b010, 32'h22, 32'hCAFEF00D, 1'b0, "sw22", d);
        applyStimulus(1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, "lw20", d);
`ifdef DMEM_MISALIGN_TRAP_EN
        checkOutput("lw20_lit", d, 32'h00000000);
`else
        checkOutput("lw20_lit", d, 32'hCAFEF00D);
`endif
        applyStimulus(1, 1'b0, 3'b011, 32'h10, 32'h0, 1'b0, "ldIllegal", d);
        checkOutput("ldIllegal_lit", d, 32'h00000000);
        applyStimulus(1, 1'b1, 3'b011, 32'h10, 32'h11223344, 1'b0, "stIllegal", d);
        applyStimulus(1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, "lw10b", d);
        checkOutput("lw10b_lit", d, 32'hDEAD55EF);
        applyStimulus(1, 1'b0, 3'b010, 32'h2000, 32'h0, 1'b0, "lwWrap", d);
        checkOutput("lwWrap_lit", d, 32'h00000007);
        applyStimulus(1, 1'b0, 3'b001, 32'h13, 32'h0, 1'b0, "lhOdd", d);

        // Back-to-back on the slow instance: each request is accepted in the previous response cycle.
        applyStimulus(3, 1'b1, 3'b010, 32'h40, 32'h12345678, 1'b1, "l3sw40", d);
        applyStimulus(3, 1'b0, 3'b010, 32'h40, 32'h0, 1'b1, "l3lw40", d);
        checkOutput("l3lw40_lit", d, 32'h12345678);
        applyStimulus(3, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, "l3lw0", d);
        checkOutput("l3lw0_lit", d, 32'h00000007);

        // Reset while BUSY drops the pending store.
        driveReq(3, 1'b1, 1'b1, 3'b010, 32'h40, 32'hAAAAAAAA);
        @(negedge clk);
        driveReq(3, 1'b0, 1'b0, 3'h0, 32'h0, 32'h0);
        rst3 = 1'b1;
        @(negedge clk);
        rst3 = 1'b0;
        sampleBus(3, rdy, rv, rd, rf);
        checkOutput("abort_ready", {31'h0, rdy}, 32'h1);
        rvSeen = 0;
        for (int c = 0; c < 5; c++) begin
            sampleBus(3, rdy, rv, rd, rf);
            if (rv) rvSeen++;
            if (c < 4) @(negedge clk);
        end
        checkOutput("abort_noResp", 32'(rvSeen), 32'h0);
        applyStimulus(3, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, "abortLw", d);
        checkOutput("abortLw_lit", d, 32'h12345678);

        // Reset and a request in the same cycle: the request is lost.
        rst3 = 1'b1;
        driveReq(3, 1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
        @(negedge clk);
        rst3 = 1'b0;
        driveReq(3, 1'b0, 1'b0, 3'h0, 32'h0, 32'h0);
        sampleBus(3, rdy, rv, rd, rf);
        checkOutput("rstReq_ready", {31'h0, rdy}, 32'h1);
        rvSeen = 0;
        for (int c = 0; c < 5; c++) begin
            sampleBus(3, rdy, rv, rd, rf);
            if (rv) rvSeen++;
            @(negedge clk);
        end
        checkOutput("rstReq_noResp", 32'(rvSeen), 32'h0);

        for (int s = 1; s <= 3; s += 2) begin
            for (int k = 0; k < 40; k++) begin
                a = ($urandom & 32'h3F) | (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFE000) : 32'h0);
                applyStimulus(s, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                              1'($urandom_range(0, 1)), $sformatf("rnd%0d_%0d", s, k), d);
            end
            driveReq(s, 1'b0, 1'b0, 3'h0, 32'h0, 32'h0);
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule
